// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared types and helpers for the 4-master AXI interconnect
package axi_ic_pkg;

  localparam int NUM_MASTERS = 4;

  typedef logic [NUM_MASTERS-1:0] mst_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rtr_state_e;

  function automatic logic is_onehot(input mst_sel_t sel);
    return $onehot(sel);
  endfunction

endpackage

// File: rtl/sel_fifo.sv
// rtl/sel_fifo.sv - DEPTH x one-hot master select FIFO, wrap-bit pointers
module sel_fifo
  import axi_ic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  mst_sel_t    din,
  output mst_sel_t    head,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  mst_sel_t    mem_q [DEPTH];
  mst_sel_t    mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/resp_return_router.sv
// rtl/resp_return_router.sv - steers shared slave R beats to the master owning the oldest grant
module resp_return_router
  import axi_ic_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 34
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       grant_valid,
  input  mst_sel_t                   grant_sel,
  output logic                       grant_ready,
  input  logic                       s_rvalid,
  input  logic [DATA_W-1:0]          s_rdata,
  input  logic                       s_rlast,
  output logic                       s_rready,
  output mst_sel_t                   m_rvalid,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_rlast,
  input  mst_sel_t                   m_rready,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic [7:0]                 beat_cnt,
  output logic                       sel_err
);

  localparam int CW = $clog2(DEPTH+1);

  rtr_state_e    state_q, state_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic          sel_err_q, sel_err_d;
  mst_sel_t      head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, beat, route_en;

  assign grant_ready = !full;
  assign push        = grant_valid && grant_ready && is_onehot(grant_sel);
  assign beat        = s_rvalid && s_rready;
  assign pop         = beat && s_rlast;

  sel_fifo #(.DEPTH(DEPTH)) u_sel_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (grant_sel),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      sel_err_q  <= sel_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (push) state_d = ST_BUSY;
      ST_BUSY: if (pop && !push && count == CW'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Routing reads only the registered head, so a grant pushed this cycle steers next cycle.
  always_comb begin
    route_en = (state_q == ST_BUSY) && !empty;
    m_rvalid = route_en ? (head & {NUM_MASTERS{s_rvalid}}) : '0;
    s_rready = route_en && |(head & m_rready);
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = '0;
    end else if (beat && beat_cnt_q != 8'hFF) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
    sel_err_d = grant_valid && grant_ready && !is_onehot(grant_sel);
  end

  assign m_rdata     = s_rdata;
  assign m_rlast     = s_rlast;
  assign outstanding = count;
  assign beat_cnt    = beat_cnt_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_resp_return_router.sv
// tb/tb_resp_return_router.sv - scoreboard bench for resp_return_router against a queue-based model
module tb_resp_return_router;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 34;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              grant_valid = 1'b0;
  logic [3:0]        grant_sel = '0;
  logic              grant_ready;
  logic              s_rvalid = 1'b0;
  logic [DATA_W-1:0] s_rdata = '0;
  logic              s_rlast = 1'b0;
  logic              s_rready;
  logic [3:0]        m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rlast;
  logic [3:0]        m_rready = '0;
  logic [2:0]        outstanding;
  logic [7:0]        beat_cnt;
  logic              sel_err;

  resp_return_router #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel),
    .grant_ready (grant_ready),
    .s_rvalid    (s_rvalid),
    .s_rdata     (s_rdata),
    .s_rlast     (s_rlast),
    .s_rready    (s_rready),
    .m_rvalid    (m_rvalid),
    .m_rdata     (m_rdata),
    .m_rlast     (m_rlast),
    .m_rready    (m_rready),
    .outstanding (outstanding),
    .beat_cnt    (beat_cnt),
    .sel_err     (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                mst;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } src_t;

  exp_t exp_q[$];
  src_t src_q[$];
  int   own_q[$];
  int   mdl_beats = 0;
  bit   mdl_err = 1'b0;
  bit   mon_en = 1'b0;
  bit   pre_burst = 1'b0;
  int   next_len = 0;
  int   total = 0;
  int   bad = 0;

  function automatic bit one_hot_ref(input logic [3:0] s);
    int n = 0;
    for (int i = 0; i < 4; i++) if (s[i]) n++;
    return n == 1;
  endfunction

  function automatic int sel_idx(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_burst(input int mst, input int len);
    logic [63:0] r;
    for (int b = 0; b < len; b++) begin
      r = {$urandom(), $urandom()};
      src_q.push_back('{data: r[DATA_W-1:0], last: (b == len - 1)});
      exp_q.push_back('{mst: mst, data: r[DATA_W-1:0], last: (b == len - 1)});
    end
  endtask

  // Called just after a rising edge: applies one cycle of stimulus, then advances the model.
  task automatic drive_cycle(input logic gv, input logic [3:0] gsel, input logic [3:0] mr, input bit want_rv);
    bit xfer, lst, do_push, bad_g;
    int len;
    grant_valid = gv;
    grant_sel   = gsel;
    m_rready    = mr;
    s_rvalid    = want_rv && (src_q.size() > 0);
    if (src_q.size() > 0) begin
      s_rdata = src_q[0].data;
      s_rlast = src_q[0].last;
    end else begin
      s_rdata = '0;
      s_rlast = 1'b0;
    end
    lst     = s_rlast;
    xfer    = s_rvalid && (own_q.size() > 0) && mr[own_q[0]];
    do_push = gv && (own_q.size() != DEPTH) && one_hot_ref(gsel);
    bad_g   = gv && (own_q.size() != DEPTH) && !one_hot_ref(gsel);
    @(posedge clk);
    #1;
    if (xfer) begin
      void'(src_q.pop_front());
      if (lst) begin
        void'(own_q.pop_front());
        mdl_beats = 0;
      end else if (mdl_beats < 255) begin
        mdl_beats++;
      end
    end
    if (do_push) begin
      own_q.push_back(sel_idx(gsel));
      len = (next_len != 0) ? next_len : $urandom_range(1, 4);
      if (!pre_burst) gen_burst(sel_idx(gsel), len);
      pre_burst = 1'b0;
    end
    mdl_err = bad_g;
  endtask

  always @(negedge clk) begin : monitor
    int         h;
    logic [3:0] exp_v;
    bit         exp_rdy;
    exp_t       e;
    if (mon_en) begin
      h       = (own_q.size() > 0) ? own_q[0] : -1;
      exp_v   = (h >= 0 && s_rvalid) ? 4'(1 << h) : 4'b0;
      exp_rdy = (h >= 0) && m_rready[h];
      chk("m_rvalid", m_rvalid, exp_v);
      chk("s_rready", s_rready, exp_rdy);
      chk("outstanding", outstanding, own_q.size());
      chk("grant_ready", grant_ready, own_q.size() != DEPTH);
      chk("beat_cnt", beat_cnt, mdl_beats);
      chk("sel_err", sel_err, mdl_err);
      if (s_rvalid && s_rready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_master", sel_idx(m_rvalid), e.mst);
          chk("beat_data", m_rdata, e.data);
          chk("beat_last", m_rlast, e.last);
        end
      end
    end
  end

  initial begin
    logic [3:0] gs;
    int guard;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant_ready", grant_ready, 1);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_m_rvalid", m_rvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single 3-beat burst to master 1.
    next_len = 3;
    drive_cycle(1'b1, 4'b0010, 4'b1111, 1'b0);
    repeat (3) drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);
    drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b0);

    // Fill the queue, try a fifth grant, then drain with master 3 stalled at first.
    next_len = 2;
    drive_cycle(1'b1, 4'b1000, 4'b1111, 1'b0);
    drive_cycle(1'b1, 4'b0001, 4'b1111, 1'b0);
    drive_cycle(1'b1, 4'b0100, 4'b1111, 1'b0);
    drive_cycle(1'b1, 4'b0010, 4'b1111, 1'b0);
    drive_cycle(1'b1, 4'b0001, 4'b1111, 1'b0);
    repeat (2) drive_cycle(1'b0, 4'b0000, 4'b0111, 1'b1);
    repeat (9) drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);

    // Last beat of master 0 coincides with a new grant at two outstanding.
    drive_cycle(1'b1, 4'b0001, 4'b1111, 1'b0);
    next_len = 1;
    drive_cycle(1'b1, 4'b0010, 4'b1111, 1'b0);
    drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);
    next_len = 2;
    drive_cycle(1'b1, 4'b1000, 4'b1111, 1'b1);
    repeat (4) drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);

    // Non-one-hot grant.
    drive_cycle(1'b1, 4'b0110, 4'b1111, 1'b0);
    drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b0);
    drive_cycle(1'b1, 4'b0000, 4'b1111, 1'b0);
    drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b0);

    // Long burst to exercise beat counter saturation.
    next_len = 258;
    drive_cycle(1'b1, 4'b0100, 4'b1111, 1'b0);
    repeat (258) drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);

    // Reset after beat 2 of 4; outputs must clear before the next edge.
    next_len = 4;
    drive_cycle(1'b1, 4'b0001, 4'b1111, 1'b0);
    repeat (2) drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_rvalid", m_rvalid, 0);
    chk("midrst_s_rready", s_rready, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_beat_cnt", beat_cnt, 0);
    chk("midrst_grant_ready", grant_ready, 1);
    own_q.delete();
    src_q.delete();
    exp_q.delete();
    mdl_beats   = 0;
    mdl_err     = 1'b0;
    s_rvalid    = 1'b0;
    grant_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Beat pending on an empty queue stalls; the grant arriving with it routes one cycle later.
    next_len = 2;
    gen_burst(2, 2);
    pre_burst = 1'b1;
    drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);
    drive_cycle(1'b1, 4'b0100, 4'b1111, 1'b1);
    repeat (3) drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);

    // Randomized traffic.
    next_len = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 4) == 0 && own_q.size() != DEPTH) gs = 4'($urandom());
      else gs = 4'(1 << $urandom_range(0, 3));
      drive_cycle($urandom_range(0, 2) == 0, gs,
                  ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b1111,
                  $urandom_range(0, 3) != 0);
    end

    guard = 0;
    while (src_q.size() > 0 && guard < 2000) begin
      drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b1);
      guard++;
    end
    drive_cycle(1'b0, 4'b0000, 4'b1111, 1'b0);
    chk("drain_budget", guard < 2000, 1);
    chk("drain_scoreboard", exp_q.size(), 0);
    chk("drain_model_queue", own_q.size(), 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
